// File: rtl/mist_io_pkg.sv
// Shared definitions for the MiST user_io SPI initiator: FSM states,
// user_io command codes and the SPI mode it speaks.
package mist_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] UIO_BUT_SW      = 8'h01;
  localparam logic [7:0] UIO_JOYSTICK0   = 8'h02;
  localparam logic [7:0] UIO_JOYSTICK1   = 8'h03;
  localparam logic [7:0] UIO_GET_STRING  = 8'h14;
  localparam logic [7:0] UIO_SET_STATUS2 = 8'h1E;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

endpackage

// File: rtl/spi_byte_shifter.sv
// SCK divider plus 8-bit mode-0 TX/RX shift registers; flags the final
// falling edge of each byte so the sequencer can chain the next one.
module spi_byte_shifter
  import mist_io_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       en,
  input  logic       shift_en,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       tick,
  output logic       last_fall,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             miso_p0;
  logic             miso_p1;

  assign tick      = en && (div == DIV_LAST);
  assign last_fall = shift_en && tick && sck && (bit_cnt == 3'd7);
  assign mosi      = tx_sr[7];

  // MISO synchronizer stage p0 -> p1
  always_ff @(posedge clk_sys) begin
    miso_p0 <= miso;
    miso_p1 <= miso_p0;
  end

  always_ff @(posedge clk_sys) begin
    if (shift_en && tick && !sck)
      rx_sr <= {rx_sr[6:0], miso_p1};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div       <= '0;
      sck       <= SPI_CPOL;
      bit_cnt   <= 3'd0;
      tx_sr     <= 8'h00;
      rx_byte   <= 8'h00;
      byte_done <= 1'b0;
    end else begin
      byte_done <= last_fall;
      div       <= (!en || tick) ? '0 : div + 1'b1;
      if (load) begin
        tx_sr   <= tx_byte;
        bit_cnt <= 3'd0;
        sck     <= SPI_CPOL;
      end else if (shift_en && tick) begin
        if (!sck) begin
          sck <= 1'b1;
        end else begin
          sck     <= 1'b0;
          bit_cnt <= bit_cnt + 3'd1;
          // The next byte is presented on the same falling edge, so bytes abut.
          if (bit_cnt == 3'd7) begin
            tx_sr   <= tx_byte;
            rx_byte <= rx_sr;
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/mist_spi_initiator.sv
// IO-controller side of the user_io SPI link: selects the core, sends a
// command byte plus up to MAX_BYTES payload bytes and reports MISO bytes.
module mist_spi_initiator
  import mist_io_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             cmd,
  input  logic [8*MAX_BYTES-1:0] payload,
  input  logic [3:0]             len,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             rx_byte,
  output logic                   rx_valid,
  output logic [3:0]             rx_index,
  output logic                   SPI_SCK,
  output logic                   SPI_SS_IO,
  output logic                   SPI_MOSI,
  input  logic                   SPI_MISO
);

  localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);

  state_t                 state;
  state_t                 state_next;
  logic [8*MAX_BYTES-1:0] payload_q;
  logic [3:0]             len_q;
  logic [3:0]             byte_cnt;
  logic [7:0]             next_byte;
  logic [7:0]             tx_byte;
  logic                   accept;
  logic                   tick;
  logic                   last_fall;
  logic                   en;
  logic                   shift_en;

  assign accept   = (state == IDLE) && start;
  assign en       = (state != IDLE);
  assign shift_en = (state == SHIFT);
  assign tx_byte  = (state == IDLE) ? cmd : next_byte;

  // Byte following the one in flight; zero once the payload is exhausted.
  always_comb begin
    next_byte = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((byte_cnt == 4'(i)) && (byte_cnt < len_q))
        next_byte = payload_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    SPI_SS_IO  = 1'b1;
    unique case (state)
      IDLE: begin
        if (start)
          state_next = SETUP;
      end
      SETUP: begin
        SPI_SS_IO = 1'b0;
        if (tick)
          state_next = SHIFT;
      end
      SHIFT: begin
        SPI_SS_IO = 1'b0;
        if (last_fall && (byte_cnt == len_q))
          state_next = HOLD;
      end
      HOLD: begin
        SPI_SS_IO = 1'b0;
        if (tick)
          state_next = GAP;
      end
      GAP: begin
        if (tick) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (accept) begin
      payload_q <= payload;
      len_q     <= (len > MAX_LEN) ? MAX_LEN : len;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_cnt <= 4'd0;
      rx_index <= 4'd0;
    end else if (accept) begin
      byte_cnt <= 4'd0;
      rx_index <= 4'd0;
    end else if (last_fall) begin
      byte_cnt <= byte_cnt + 4'd1;
      rx_index <= byte_cnt;
    end
  end

  spi_byte_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .en        (en),
    .shift_en  (shift_en),
    .load      (accept),
    .tx_byte   (tx_byte),
    .miso      (SPI_MISO),
    .tick      (tick),
    .last_fall (last_fall),
    .sck       (SPI_SCK),
    .mosi      (SPI_MOSI),
    .rx_byte   (rx_byte),
    .byte_done (rx_valid)
  );

endmodule

// File: tb/tb_mist_spi_initiator.sv
// Directed bench for mist_spi_initiator with a mode-0 user_io responder model.
module tb_mist_spi_initiator;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [63:0] payload = 64'h0;
  logic [3:0]  len = 4'd0;
  logic        busy, done, rx_valid;
  logic [7:0]  rx_byte;
  logic [3:0]  rx_index;
  logic        SPI_SCK, SPI_SS_IO, SPI_MOSI;
  logic        SPI_MISO = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mist_spi_initiator #(.CLK_DIV(4), .MAX_BYTES(8)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (start),
    .cmd       (cmd),
    .payload   (payload),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_index  (rx_index),
    .SPI_SCK   (SPI_SCK),
    .SPI_SS_IO (SPI_SS_IO),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO)
  );

  always #5 clk_sys = ~clk_sys;

  // Responder model and bus monitor, evaluated just after each rising edge.
  logic [7:0]  miso_first = 8'h3C;
  logic [7:0]  m_sr = 8'h00;
  int          m_bits = 0;
  logic        sck_prev = 1'b0;
  logic [7:0]  mosi_acc = 8'h00;
  int          mosi_bits = 0;
  int          sck_pulses = 0;
  int          ss_bad = 0;
  int          done_cnt = 0;
  logic [7:0]  sent_q[$];
  logic [7:0]  rxb_q[$];
  logic [3:0]  rxi_q[$];

  always @(posedge clk_sys) begin
    #1;
    if (SPI_SS_IO) begin
      m_sr      = miso_first;
      m_bits    = 0;
      mosi_bits = 0;
      if (SPI_SCK) ss_bad++;
    end else begin
      if (sck_prev && !SPI_SCK) begin
        m_bits++;
        if (m_bits == 8) begin
          m_bits = 0;
          m_sr   = 8'h00;
        end else begin
          m_sr = {m_sr[6:0], 1'b0};
        end
      end
      if (!sck_prev && SPI_SCK) begin
        sck_pulses++;
        mosi_acc = {mosi_acc[6:0], SPI_MOSI};
        mosi_bits++;
        if (mosi_bits == 8) begin
          sent_q.push_back(mosi_acc);
          mosi_bits = 0;
        end
      end
    end
    if (rx_valid) begin
      rxb_q.push_back(rx_byte);
      rxi_q.push_back(rx_index);
    end
    if (done) done_cnt++;
    sck_prev = SPI_SCK;
    SPI_MISO = m_sr[7];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    sent_q.delete();
    rxb_q.delete();
    rxi_q.delete();
    sck_pulses = 0;
    ss_bad     = 0;
    done_cnt   = 0;
  endtask

  // Launches one transfer and returns the cycle count to done (0 on timeout).
  task automatic run_txn(input logic [7:0] c, input logic [63:0] p, input logic [3:0] l,
                         input int budget, input int repulse_at, output int cycles);
    int cnt;
    clear_mon();
    @(negedge clk_sys);
    cmd = c; payload = p; len = l; start = 1'b1;
    @(posedge clk_sys);
    cnt = 0;
    cycles = 0;
    while (cnt < budget) begin
      @(negedge clk_sys);
      cnt++;
      start   = (cnt == repulse_at);
      cmd     = 8'hFF;
      payload = '1;
      len     = 4'd8;
      if (done) begin
        cycles = cnt;
        break;
      end
    end
    start = 1'b0;
    if (cycles == 0) check_val("timeout", 32'(cnt), 32'(budget + 1));
    @(negedge clk_sys);
  endtask

  initial begin
    int cyc;
    int idle_bad;

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    check_val("rst_ss", 32'(SPI_SS_IO), 32'd1);
    check_val("rst_sck", 32'(SPI_SCK), 32'd0);
    check_val("rst_mosi", 32'(SPI_MOSI), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rxbyte", 32'(rx_byte), 32'd0);
    check_val("rst_rxidx", 32'(rx_index), 32'd0);
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (SPI_SS_IO !== 1'b1 || SPI_SCK !== 1'b0 || SPI_MOSI !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || rx_valid !== 1'b0)
        idle_bad++;
    end
    check_val("idle_quiet", 32'(idle_bad), 32'd0);

    // JOYSTICK0 with one payload byte
    run_txn(8'h02, 64'hA5, 4'd1, 400, 0, cyc);
    check_val("j0_cycles", 32'(cyc), 32'd140);
    check_val("j0_nsent", 32'(sent_q.size()), 32'd2);
    if (sent_q.size() == 2) begin
      check_val("j0_byte0", 32'(sent_q[0]), 32'h02);
      check_val("j0_byte1", 32'(sent_q[1]), 32'hA5);
    end
    check_val("j0_pulses", 32'(sck_pulses), 32'd16);
    check_val("j0_ss", 32'(ss_bad), 32'd0);
    check_val("j0_busy_after", 32'(busy), 32'd0);
    check_val("j0_done_cnt", 32'(done_cnt), 32'd1);

    // SET_STATUS2 with four bytes and a returned 3C
    run_txn(8'h1E, 64'h12345678, 4'd4, 600, 0, cyc);
    check_val("st_cycles", 32'(cyc), 32'd332);
    check_val("st_nsent", 32'(sent_q.size()), 32'd5);
    if (sent_q.size() == 5) begin
      check_val("st_byte0", 32'(sent_q[0]), 32'h1E);
      check_val("st_byte1", 32'(sent_q[1]), 32'h78);
      check_val("st_byte2", 32'(sent_q[2]), 32'h56);
      check_val("st_byte3", 32'(sent_q[3]), 32'h34);
      check_val("st_byte4", 32'(sent_q[4]), 32'h12);
    end
    check_val("st_nrx", 32'(rxb_q.size()), 32'd5);
    if (rxb_q.size() == 5) begin
      check_val("st_rx0", 32'(rxb_q[0]), 32'h3C);
      check_val("st_rx4", 32'(rxb_q[4]), 32'h00);
      for (int i = 0; i < 5; i++) check_val("st_rxidx", 32'(rxi_q[i]), 32'(i));
    end

    // Oversized len clamps to 8 payload bytes
    run_txn(8'h14, 64'h8877665544332211, 4'd15, 800, 0, cyc);
    check_val("cl_cycles", 32'(cyc), 32'd588);
    check_val("cl_nsent", 32'(sent_q.size()), 32'd9);
    if (sent_q.size() == 9) begin
      check_val("cl_byte1", 32'(sent_q[1]), 32'h11);
      check_val("cl_byte8", 32'(sent_q[8]), 32'h88);
    end
    check_val("cl_rxidx_end", 32'(rx_index), 32'd8);

    // start while busy is ignored
    run_txn(8'h01, 64'h0, 4'd0, 200, 30, cyc);
    check_val("ig_cycles", 32'(cyc), 32'd76);
    check_val("ig_nsent", 32'(sent_q.size()), 32'd1);
    if (sent_q.size() == 1) check_val("ig_byte0", 32'(sent_q[0]), 32'h01);
    repeat (100) @(negedge clk_sys);
    check_val("ig_done_cnt", 32'(done_cnt), 32'd1);
    check_val("ig_idle_busy", 32'(busy), 32'd0);
    run_txn(8'h03, 64'h0, 4'd0, 200, 0, cyc);
    check_val("ig_next_cycles", 32'(cyc), 32'd76);

    // Reset in the middle of the command byte
    clear_mon();
    @(negedge clk_sys);
    cmd = 8'hC3; payload = 64'h0; len = 4'd2; start = 1'b1;
    @(posedge clk_sys);
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk_sys);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    check_val("ab_ss", 32'(SPI_SS_IO), 32'd1);
    check_val("ab_sck", 32'(SPI_SCK), 32'd0);
    check_val("ab_busy", 32'(busy), 32'd0);
    repeat (100) @(negedge clk_sys);
    check_val("ab_nrx", 32'(rxb_q.size()), 32'd0);
    check_val("ab_done_cnt", 32'(done_cnt), 32'd0);
    run_txn(8'h02, 64'h5A, 4'd1, 400, 0, cyc);
    check_val("ab_fresh_cycles", 32'(cyc), 32'd140);
    if (sent_q.size() == 2) check_val("ab_fresh_byte1", 32'(sent_q[1]), 32'h5A);
    else check_val("ab_fresh_nsent", 32'(sent_q.size()), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
